// File: rtl/poly_arith_pkg.sv
// Shared constants for the q = 3329 polynomial arithmetic datapath.
package poly_arith_pkg;

  localparam int Q         = 3329;
  // -q^-1 mod 2^16, used by the Montgomery reduction
  localparam int Q_INV_NEG = 3327;
  // R^2 mod q and R mod q for R = 2^16
  localparam int R2_MOD_Q  = 1353;
  localparam int R_MOD_Q   = 2285;

  localparam int unsigned PROD_W  = 32;
  localparam int unsigned COEFF_W = 16;

endpackage

// File: rtl/coeff_frame_counter.sv
// Per-polynomial coefficient index counter with wrap and last-flag generation.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   advance     in   one coefficient handed off this cycle
//   idx         out  index of the current coefficient (registered)
//   at_last_c   out  idx is the final index of the polynomial
module coeff_frame_counter #(
  parameter int unsigned N_COEFFS = 256,
  parameter int unsigned IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             at_last_c
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFFS - 1);

  assign at_last_c = (idx == LAST_IDX);

  // Wrap on the final handoff so back-to-back polynomials need no gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (advance) begin
      idx <= at_last_c ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/modular_reduce.sv
// Combinational Montgomery reduction: t = z * R^-1 mod q, with R = 2^16.
// Ports:
//   z    in  32  signed product, |z| < q*2^15
//   t_c  out 16  signed result in (-q, q)
module modular_reduce
  import poly_arith_pkg::*;
(
  input  logic signed [PROD_W-1:0]  z,
  output logic signed [COEFF_W-1:0] t_c
);

  logic signed [COEFF_W-1:0] m;
  logic signed [PROD_W-1:0]  sum;

  // m is taken as signed so m*q stays within +-q*2^15, keeping |t| < q
  always_comb begin
    m   = COEFF_W'(z * PROD_W'(Q_INV_NEG));
    sum = z + PROD_W'(m) * PROD_W'(Q);
    t_c = COEFF_W'(sum >>> 16);
  end

endmodule

// File: rtl/mont_domain_convert.sv
// Streaming conversion of coefficients into the Montgomery domain:
// a -> a*R mod q by multiplying with R^2 mod q and Montgomery-reducing.
// Two-stage pipeline, valid/ready on both sides, per-polynomial framing.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   valid_i        input coefficient valid
//   ready_o        block accepts a coefficient this cycle (from ready_i)
//   coeff_i        signed input coefficient, |a| < 2^15
//   valid_o        output coefficient valid
//   ready_i        downstream accepts output
//   coeff_o        signed Montgomery-domain coefficient in (-q, q)
//   last_o         final coefficient of a polynomial
//   idx_o          index of the current output within its polynomial
module mont_domain_convert
  import poly_arith_pkg::*;
#(
  parameter int unsigned N_COEFFS = 256,
  parameter int          R2_MOD_Q = poly_arith_pkg::R2_MOD_Q
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [COEFF_W-1:0] coeff_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic signed [COEFF_W-1:0] coeff_o,
  output logic                      last_o,
  output logic [7:0]                idx_o
);

  localparam int unsigned IDX_W = 8;

  logic                      adv_c;
  logic                      s1_valid;
  logic signed [PROD_W-1:0]  s1_prod;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [COEFF_W-1:0] red_c;
  logic                      at_last_c;

  // Whole pipeline moves whenever the output slot is empty or being drained
  assign adv_c   = !valid_o || ready_i;
  assign ready_o = adv_c;

  assign prod_c = PROD_W'(coeff_i) * PROD_W'(R2_MOD_Q);

  modular_reduce u_reduce (
    .z   (s1_prod),
    .t_c (red_c)
  );

  // Stage 1 holds the product, stage 2 the reduced result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      valid_o  <= 1'b0;
      coeff_o  <= '0;
    end else if (adv_c) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_prod <= prod_c;
      end
      valid_o <= s1_valid;
      if (s1_valid) begin
        coeff_o <= red_c;
      end
    end
  end

  coeff_frame_counter #(
    .N_COEFFS (N_COEFFS),
    .IDX_W    (IDX_W)
  ) u_frame (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .advance   (valid_o && ready_i),
    .idx       (idx_o),
    .at_last_c (at_last_c)
  );

  assign last_o = valid_o && at_last_c;

endmodule

// File: tb/tb_mont_domain_convert.sv
// Self-checking bench for mont_domain_convert.
module tb_mont_domain_convert;

  localparam int N  = 256;
  localparam int QV = 3329;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               valid_i = 1'b0;
  logic               ready_o;
  logic signed [15:0] coeff_i = '0;
  logic               valid_o;
  logic               ready_i = 1'b1;
  logic signed [15:0] coeff_o;
  logic               last_o;
  logic [7:0]         idx_o;

  mont_domain_convert #(.N_COEFFS(N)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .coeff_i (coeff_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .coeff_o (coeff_o),
    .last_o  (last_o),
    .idx_o   (idx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_last = 0;
  int send_waits = 0;
  bit rand_mode = 1'b0;

  // model state
  int in_q[$];
  int cnt = 0;
  bit prev_stall = 1'b0;
  int prev_coeff = 0;
  int prev_idx = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // a*R mod q via Montgomery reduction of a*(R^2 mod q), signed-centred m
  function automatic int gold(input int a);
    longint z, m;
    z = longint'(a) * 1353;
    m = (z * 3327) & 64'sd65535;
    if (m >= 32768) m = m - 65536;
    return int'((z + m * QV) / 65536);
  endfunction

  // Compare process: outputs and handshakes are final at the falling edge
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      in_q.delete();
      cnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("ready_o", ready_o, !valid_o || ready_i);
      if (valid_o) begin
        if (in_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("coeff_o", coeff_o, gold(in_q[0]));
          chk("range", (coeff_o > -QV && coeff_o < QV), 1);
          chk("congruent", (longint'(coeff_o) - longint'(in_q[0]) * 2285) % QV, 0);
        end
        chk("idx_o", idx_o, cnt);
        chk("last_o", last_o, cnt == N - 1);
        if (prev_stall) begin
          chk("stall_coeff", coeff_o, prev_coeff);
          chk("stall_idx", idx_o, prev_idx);
        end
        if (ready_i) begin
          if (in_q.size() != 0) void'(in_q.pop_front());
          cnt = (cnt + 1) % N;
          n_out++;
          if (last_o) n_last++;
        end
      end else begin
        chk("last_idle", last_o, 0);
      end
      prev_stall = valid_o && !ready_i;
      prev_coeff = coeff_o;
      prev_idx   = idx_o;
      if (valid_i && ready_o) in_q.push_back(int'(coeff_i));
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rand_mode) ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Present one coefficient and hold it until accepted
  task automatic send(input int a);
    bit acc;
    int guard = 0;
    valid_i = 1'b1;
    coeff_i = 16'(a);
    do begin
      @(negedge clk_i);
      acc = ready_o;
      if (!acc) send_waits++;
      guard++;
    end while (!acc && guard < 2000);
    if (!acc) chk("send_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((in_q.size() != 0 || valid_o) && guard < 5000) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    chk("drain", in_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_coeff", coeff_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_idx", idx_o, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Wait for the next output and check it against a hand-computed value
  task automatic expect_out(input string name, input int exp_c, input int exp_i);
    int guard = 0;
    @(negedge clk_i);
    while (!valid_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    chk({name, "_valid"}, valid_o, 1);
    chk({name, "_coeff"}, coeff_o, exp_c);
    chk({name, "_idx"}, idx_o, exp_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int base_out, base_last, base_waits, guard;

    // model pins
    chk("gold_1", gold(1), -1044);
    chk("gold_m1", gold(-1), 1044);
    chk("gold_q", gold(3329), 0);
    chk("gold_7", gold(7), -650);

    #12;
    chk("init_valid", valid_o, 0);
    chk("init_idx", idx_o, 0);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_valid", valid_o, 0);

    // latency: output appears after exactly two edges
    send(1);
    chk("lat1_valid", valid_o, 0);
    @(posedge clk_i);
    #1;
    chk("lat2_valid", valid_o, 1);
    chk("lat2_coeff", coeff_o, -1044);
    chk("lat2_idx", idx_o, 0);
    idle(2);

    send(0);     expect_out("zero", 0, 1);
    send(3329);  expect_out("q", 0, 2);
    send(-1);    expect_out("neg1", 1044, 3);
    idle(2);

    // two back-to-back polynomials at full rate
    do_reset();
    base_out = n_out; base_last = n_last; base_waits = send_waits;
    for (int i = 0; i < 2 * N; i++) send((i * 131) % 65535 - 32767);
    wait_drain();
    chk("stream_outs", n_out - base_out, 2 * N);
    chk("stream_lasts", n_last - base_last, 2);
    chk("stream_waits", send_waits - base_waits, 0);

    // stall with pipeline full
    ready_i = 1'b0;
    valid_i = 1'b1; coeff_i = 16'sd1000;
    @(posedge clk_i); #1;
    coeff_i = -16'sd2000;
    @(posedge clk_i); #1;
    coeff_i = 16'sd3000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("stall_ready", ready_o, 0);
      chk("stall_valid", valid_o, 1);
      chk("stall_val", coeff_o, gold(1000));
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    expect_out("drain_b", gold(-2000), 1);
    expect_out("drain_c", gold(3000), 2);
    wait_drain();

    // random backpressure and input gaps
    base_out = n_out;
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      send(int'($urandom_range(0, 65534)) - 32767);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    rand_mode = 1'b0;
    ready_i = 1'b1;
    wait_drain();
    chk("rand_outs", n_out - base_out, 10000);

    // reset mid-polynomial with the pipeline full
    guard = 0;
    while (!(valid_o && idx_o == 8'd100) && guard < 600) begin
      send(int'($urandom_range(0, 65534)) - 32767);
      guard++;
    end
    chk("reach_idx100", idx_o, 100);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_idx", idx_o, 0);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    send(7);
    expect_out("after_rst", -650, 0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    n_chk++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mont_domain_convert.md
Name: mont_domain_convert

Overview:
- Streaming converter that moves polynomial coefficients into the Montgomery domain: a -> a*R mod q, with R = 2^16 and q = 3329.
- It is the complement of `modular_reduce`, which strips a factor of R. This block adds one by multiplying by R^2 mod q (1353) and then Montgomery-reducing.
- Sits between coefficient sources (sampler/decoder) and the NTT/pointwise multiply datapath.
- Handles one coefficient per cycle with a valid/ready handshake, a 2-stage pipeline and per-polynomial framing.

Parameters:
- N_COEFFS, 256, coefficients per polynomial; sets the `last_o` framing.
- R2_MOD_Q, 1353, constant multiplier (R^2 mod q); the default comes from `poly_arith_pkg`.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input coefficient valid
- ready_o  out  1  block can accept a coefficient this cycle
- coeff_i  in  16  signed input coefficient; legal range |a| < 2^15
- valid_o  out  1  output coefficient valid
- ready_i  in  1  downstream accepts output
- coeff_o  out  16  signed Montgomery-domain coefficient, range (-q, q)
- last_o  out  1  high with the N_COEFFS-th output of each polynomial
- idx_o  out  8  index within the polynomial of the current output (0..N_COEFFS-1)

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, idx counter = 0. Outputs: valid_o=0, coeff_o=0, last_o=0, idx_o=0, and ready_o=1 immediately after reset.
- Pipeline enable: adv = !valid_o || ready_i. `ready_o = adv` (combinational path from ready_i is permitted; the downstream must not make ready_i depend on ready_o).
- Stage 1, on adv:
  - s1_valid <= valid_i.
  - If valid_i, s1_prod <= coeff_i * R2_MOD_Q as a 32-bit signed value.
- Stage 2, on adv:
  - valid_o <= s1_valid.
  - If s1_valid, coeff_o <= montgomery(s1_prod), where m = 16'(z * Q_INV_NEG) (Q_INV_NEG = 3327) and t = (z + m*q) >>> 16, truncated to 16 bits.
- Latency: exactly 2 cycles from an accepted input to valid_o, when ready_i stays high. Throughput is 1 coefficient per cycle.
- Stall (ready_i=0 with valid_o=1):
  - coeff_o, valid_o, idx_o, last_o, s1 contents and the counter all hold.
  - ready_o=0.
  - No data is lost or duplicated.
- Bubbles: valid_i=0 while adv=1 inserts a bubble, and bubbles collapse. A stage holding no valid data never blocks.
- Framing:
  - idx counter increments on each output handshake (valid_o && ready_i).
  - idx_o = counter, and last_o = valid_o && (counter == N_COEFFS-1).
  - On the handshake where last_o=1, the counter wraps to 0.
  - Back-to-back polynomials need no gap.
- Arithmetic:
  - Output is congruent to a*2285 mod q (2285 = R mod q).
  - |coeff_o| < q is guaranteed for legal inputs, since |z| <= 32767*1353 < q*R.
  - Inputs outside the legal range are undefined.
- Reset mid-stream: in-flight data and a partial polynomial count are discarded. valid_o drops asynchronously and the counter returns to 0.
- Simultaneous events: an input accept, a stage-1-to-stage-2 move and an output handshake can all happen in the same cycle.

Decomposition:
- In `poly_arith_pkg` (reused): Q, Q_INV_NEG. Add R2_MOD_Q=1353 and R_MOD_Q=2285 there.
- Instantiate the existing `modular_reduce` combinationally between s1_prod and the stage-2 register. Do not reimplement the reduction.
- One new small sub-module is natural: `coeff_frame_counter` (idx counter, wrap, last generation), which is reusable by other streaming blocks.

Test Plan:
- Reset then coeff_i=1, valid_i=1, ready_i=1 -> two cycles later valid_o=1, coeff_o=-1044 (≡2285 mod q), idx_o=0.
- Inputs 0 and 3329 -> both produce coeff_o=0. Input -1 -> coeff_o=1044.
- Stream 256 coefficients with ready_i=1 -> exactly 256 outputs, idx_o 0..255, last_o only on idx 255. Stream 256 more immediately -> idx restarts at 0 with no idle cycle.
- Random ready_i at 50% plus random valid_i gaps over 10,000 coefficients, each in ±32767:
  - output order preserved, no loss or duplication;
  - every coeff_o equals the golden montgomery(a*1353), is in (-q,q) and ≡ a*2285 mod q;
  - outputs hold stable while stalled.
- Hold ready_i=0 for 5 cycles with the pipeline full -> ready_o=0, coeff_o/idx_o unchanged. Release -> outputs drain in order.
- Assert rst_ni low mid-polynomial (idx_o=100, pipeline full) -> valid_o=0 immediately. After release, the first new output has idx_o=0 and the old data never appears.
